// File: rtl/bitwise_logic_unit.sv
// Multi-cycle bitwise logic unit: SLICE bits per cycle, start/result-ready handshake.
// Optional LOGIC_REDUCE_EN adds data_nonzero, the OR-reduction of the result.
`timescale 1ns/1ps
module bitwise_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_start,
    input  logic [2:0]       ctrl_op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
    output logic             data_exception,
`ifdef LOGIC_REDUCE_EN
    output logic             data_nonzero,
`endif
    output logic             busy
);
    // state | meaning
    // IDLE  | waiting for ctrl_start; an invalid op raises its pulse one edge later
    // RUN   | writing slice cnt of the working register, cnt = 0..N-1
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_lat, b_lat, work, work_nxt;
    logic [2:0]       op_lat;
    logic             inv_pend;
    logic [SLICE-1:0] a_sl, b_sl, r_sl;
    logic             start_ok, start_bad, last;

    assign start_ok  = (state == IDLE) && ctrl_start && (ctrl_op != 3'b111);
    assign start_bad = (state == IDLE) && ctrl_start && (ctrl_op == 3'b111);
    assign last      = (state == RUN) && (cnt == LAST);
    assign busy      = (state == RUN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Constant-index slice mux keeps the part-selects static
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                a_sl = a_lat[i*SLICE +: SLICE];
                b_sl = b_lat[i*SLICE +: SLICE];
            end
        end
        case (op_lat)
            3'b000:  r_sl = a_sl & b_sl;
            3'b001:  r_sl = a_sl | b_sl;
            3'b010:  r_sl = a_sl ^ b_sl;
            3'b011:  r_sl = ~(a_sl | b_sl);
            3'b100:  r_sl = ~(a_sl & b_sl);
            3'b101:  r_sl = ~(a_sl ^ b_sl);
            3'b110:  r_sl = a_sl & ~b_sl;
            default: r_sl = '0;
        endcase
        work_nxt = work;
        for (int i = 0; i < N; i++) begin
            if (cnt == CW'(i)) work_nxt[i*SLICE +: SLICE] = r_sl;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt            <= '0;
            a_lat          <= '0;
            b_lat          <= '0;
            op_lat         <= '0;
            work           <= '0;
            inv_pend       <= 1'b0;
            data_result    <= '0;
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
            inv_pend       <= start_bad;
            if (start_ok) begin
                a_lat  <= operandA;
                b_lat  <= operandB;
                op_lat <= ctrl_op;
                work   <= '0;
                cnt    <= '0;
            end else if (state == RUN) begin
                work <= work_nxt;
                cnt  <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    data_result    <= work_nxt;
                    data_resultRDY <= 1'b1;
                end
            end
            if (inv_pend) begin
                data_result    <= '0;
                data_resultRDY <= 1'b1;
                data_exception <= 1'b1;
            end
        end
    end

`ifdef LOGIC_REDUCE_EN
    logic nz_acc;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            nz_acc       <= 1'b0;
            data_nonzero <= 1'b0;
        end else begin
            if (start_ok)
                nz_acc <= 1'b0;
            else if (state == RUN)
                nz_acc <= nz_acc | (|r_sl);
            if (last)
                data_nonzero <= nz_acc | (|r_sl);
            if (inv_pend)
                data_nonzero <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench for bitwise_logic_unit: directed table, corner sequences, random ops.
// Build with LOGIC_REDUCE_EN defined to also check data_nonzero.
`timescale 1ns/1ps
module tb_bitwise_logic_unit;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_start = 1'b0;
    logic [2:0]  ctrl_op = 3'd0;
    logic [31:0] operandA = '0;
    logic [31:0] operandB = '0;
    logic [31:0] data_result;
    logic        data_resultRDY, data_exception, busy;
`ifdef LOGIC_REDUCE_EN
    logic        data_nonzero;
`endif

    bitwise_logic_unit #(.WIDTH(32), .SLICE(8)) dut (
        .clock(clock), .reset_n(reset_n), .ctrl_start(ctrl_start), .ctrl_op(ctrl_op),
        .operandA(operandA), .operandB(operandB), .data_result(data_result),
        .data_resultRDY(data_resultRDY), .data_exception(data_exception),
`ifdef LOGIC_REDUCE_EN
        .data_nonzero(data_nonzero),
`endif
        .busy(busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    logic [31:0] last_res = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;
    vec_t vecs[8];

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a | b);
            3'd4: return ~(a & b);
            3'd5: return ~(a ^ b);
            3'd6: return a & ~b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Returns #1 after the edge that samples the start; scrambles inputs afterwards.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_start = 1'b1;
        ctrl_op    = op;
        operandA   = a;
        operandB   = b;
        @(posedge clock);
        #1;
        ctrl_start = 1'b0;
        operandA   = $urandom;
        operandB   = $urandom;
        ctrl_op    = 3'($urandom_range(0, 6));
    endtask

    task automatic wait_done(input int inject, input logic [31:0] held,
                             output int lat, output int bcnt, output int hold_bad);
        lat = 0;
        hold_bad = 0;
        bcnt = busy ? 1 : 0;
        chk("rdy_cleared", 32'(data_resultRDY), 32'd0);
        while (1) begin
            @(posedge clock);
            #1;
            lat++;
            if (lat == inject + 1) ctrl_start = 1'b0;
            if (data_resultRDY) break;
            if (busy) bcnt++;
            if (data_result !== held) hold_bad++;
            if (lat == inject) begin
                ctrl_start = 1'b1;
                ctrl_op    = 3'd0;
                operandA   = 32'h0;
                operandB   = 32'h0;
            end
            if (lat >= 20) break;
        end
        ctrl_start = 1'b0;
    endtask

    task automatic run_check(input string name, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_res,
                             input logic exp_exc, input int inject);
        int lat, bcnt, hold_bad;
        issue(op, a, b);
        wait_done(inject, last_res, lat, bcnt, hold_bad);
        chk({name, "_latency"}, 32'(lat), exp_exc ? 32'd1 : 32'd4);
        chk({name, "_result"}, data_result, exp_res);
        chk({name, "_exception"}, 32'(data_exception), 32'(exp_exc));
        chk({name, "_busy_cycles"}, 32'(bcnt), exp_exc ? 32'd0 : 32'd4);
        chk({name, "_held"}, 32'(hold_bad), 32'd0);
`ifdef LOGIC_REDUCE_EN
        chk({name, "_nonzero"}, 32'(data_nonzero), 32'((exp_res != 0) && !exp_exc));
`endif
        last_res = exp_res;
    endtask

    initial begin
        int pulses;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        vecs[0] = '{3'd0, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00F0_0034, 1'b0};
        vecs[1] = '{3'd1, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFFF0_12FF, 1'b0};
        vecs[2] = '{3'd2, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFF00_12CB, 1'b0};
        vecs[3] = '{3'd3, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h000F_ED00, 1'b0};
        vecs[4] = '{3'd4, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFF0F_FFCB, 1'b0};
        vecs[5] = '{3'd5, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00FF_ED34, 1'b0};
        vecs[6] = '{3'd6, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hF000_1200, 1'b0};
        vecs[7] = '{3'd7, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h0000_0000, 1'b1};

        // Reset values
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_result", data_result, 32'd0);
        chk("reset_rdy", 32'(data_resultRDY), 32'd0);
        chk("reset_exception", 32'(data_exception), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
`ifdef LOGIC_REDUCE_EN
        chk("reset_nonzero", 32'(data_nonzero), 32'd0);
`endif

        run_check("or", 3'd1, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFFF0_12FF, 1'b0, -1);

        // Back-to-back: second start lands in the RDY cycle of the first
        run_check("b2b_xor", 3'd2, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFF00_12CB, 1'b0, -1);
        run_check("b2b_andn", 3'd6, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hF000_1200, 1'b0, -1);

        // NOR of zeros with an ignored start one cycle into RUN
        run_check("nor_zero", 3'd3, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1);
        pulses = 0;
        repeat (6) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        chk("nor_extra_pulses", 32'(pulses), 32'd0);
        chk("nor_result_kept", data_result, 32'hFFFF_FFFF);
        chk("nor_idle_busy", 32'(busy), 32'd0);

        run_check("invalid", 3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1, -1);

        // Reset after two slices are written
        issue(3'd6, 32'hDEAD_BEEF, 32'h0000_FFFF);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_result", data_result, 32'd0);
        chk("midrst_rdy", 32'(data_resultRDY), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        last_res = 32'd0;
        pulses = 0;
        repeat (8) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        chk("midrst_no_pulse", 32'(pulses), 32'd0);
        run_check("after_rst", 3'd0, 32'hFFFF_0000, 32'hF0F0_F0F0, 32'hF0F0_0000, 1'b0, -1);

        foreach (vecs[i])
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                      vecs[i].res, vecs[i].exc, -1);

        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            run_check($sformatf("rand%0d", k), rop, ra, rb, model(rop, ra, rb), rop == 3'd7, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bitwise_logic_unit.md
# bitwise_logic_unit

- Parametrised, multi-cycle bitwise logic unit for the processor datapath.
- Supports six logic operations (AND, OR, XOR, NOR, NAND, XNOR) plus AND-NOT, selected per request.
- Processes operands SLICE bits per cycle and returns results through the same start/result-ready handshake as the multdiv unit.
- Sits beside multdiv in the execute stage, taking long-form logic ops off the single-cycle ALU path.

## Interface
- WIDTH, 32, operand/result width in bits
- SLICE, 8, bits processed per cycle; must divide WIDTH; N = WIDTH/SLICE cycles per operation
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- ctrl_start  input  1  request; sampled only when idle
- ctrl_op  input  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 NAND, 101 XNOR, 110 ANDN (A & ~B), 111 invalid
- operandA  input  WIDTH  first operand; sampled with ctrl_start
- operandB  input  WIDTH  second operand; sampled with ctrl_start
- data_result  output  WIDTH  last completed result; held until next completion
- data_resultRDY  output  1  one-cycle completion pulse
- data_exception  output  1  one-cycle pulse with data_resultRDY on invalid op
- busy  output  1  operation in progress

## Operation
**States**
- IDLE
- RUN: slice counter 0..N-1

**IDLE**
- On ctrl_start with a valid op: latch operandA, operandB and ctrl_op; clear the working register and counter; enter RUN.
- On ctrl_start with op 111: stay IDLE. Next edge sets data_resultRDY=1, data_exception=1 and data_result=0.

**RUN**
- Each edge computes slice [cnt*SLICE +: SLICE] from the latched operands and writes it to the working register, then increments cnt.
- On the edge where cnt==N-1:
  - copy the full working value (including the final slice) to data_result;
  - pulse data_resultRDY;
  - return to IDLE.
- ctrl_start while in RUN is ignored; changes to operandA/B/op during RUN have no effect.

**Outputs**
- data_resultRDY and data_exception are registered pulses, cleared the following edge.
- busy = (state==RUN).

**Reset**
- reset_n low (any time, including mid-RUN) clears immediately: state IDLE, cnt 0, working register 0, data_result 0, data_resultRDY 0, data_exception 0, busy 0.
- An aborted operation produces no pulse.

**Degenerate case**
- N=1 (SLICE==WIDTH): RUN lasts one cycle; latency 1.

## Timing
- Start sampled at edge E0; slices written at E1..EN.
- data_resultRDY high for the cycle after EN; busy high after E0 through EN.
- Latency N cycles (4 at defaults) for a valid op; 1 cycle for an invalid op.
- Back-to-back: a ctrl_start during the data_resultRDY cycle is accepted, giving throughput one op per N+0 cycles (no bubble).
- data_result changes only at the completion edge; it is stable throughout RUN.

## Configuration
- LOGIC_REDUCE_EN defined:
  - adds output data_nonzero (1 bit), the OR-reduction of the result;
  - accumulated incrementally per slice as a sticky bit cleared on start;
  - registered alongside data_result at completion;
  - reset 0; forced 0 on invalid op.
- Undefined: port and accumulator absent; all other behaviour identical.

## Test plan
- **Reset values:** assert reset_n=0 then release, idle 3 cycles -> data_result=0, data_resultRDY=0, data_exception=0, busy=0.
- **OR at defaults:** A=0xF0F0_1234, B=0x0FF0_00FF, op=001 -> data_resultRDY exactly 4 cycles after start, data_result=0xFFF0_12FF, busy high 4 cycles; with LOGIC_REDUCE_EN, data_nonzero=1.
- **Back-to-back XOR then ANDN:** same operands, XOR issued, ANDN issued in the RDY cycle -> 0xFF00_12CB, then 0xF000_1200 four cycles later; first result held throughout the second RUN.
- **NOR of zeros and ignored start:** A=B=0, op=011 -> 0xFFFF_FFFF; a second ctrl_start with op=000 mid-RUN is ignored (single RDY pulse, result unchanged).
- **Invalid op:** op=111 -> one cycle later data_resultRDY=1 and data_exception=1 for one cycle, data_result=0, busy never asserted.
- **Reset mid-RUN:** drop reset_n for half a cycle at cnt=2 -> outputs clear asynchronously, no RDY pulse follows, next op completes normally.
